// File: rtl/pet_pkg.sv
// Shared definitions for the pet core: stat channel indices, default sizing
// and a small popcount helper used for the critical-condition threshold.
package pet_pkg;

    localparam int STAT_HUNGER    = 0;
    localparam int STAT_HAPPINESS = 1;
    localparam int STAT_HEALTH    = 2;
    localparam int STAT_HYGIENE   = 3;
    localparam int STAT_ENERGY    = 4;
    localparam int STAT_SOCIAL    = 5;

    localparam int PET_STAT_W    = 4;
    localparam int PET_NUM_STATS = 6;

    // Up to 16 stat channels are supported, so a 16-bit operand covers all.
    function automatic int popcount(input logic [15:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/pet_stats_engine_if.sv
// Care-request handshake between the action decoder (master) and the
// stats engine (slave).
//   care_valid : request present
//   care_id    : target stat index
//   care_ready : engine can accept a request this cycle
interface pet_stats_engine_if
    import pet_pkg::*;
#(
    parameter int NUM_STATS = PET_NUM_STATS
) ();
    localparam int ID_W = $clog2(NUM_STATS);

    logic            care_valid;
    logic [ID_W-1:0] care_id;
    logic            care_ready;

    modport master (output care_valid, care_id, input care_ready);
    modport slave  (input care_valid, care_id, output care_ready);
endinterface

// File: rtl/pet_stat_cell.sv
// One saturating need counter. inc_en adds DECAY_STEP, dec_en subtracts
// CARE_STEP; both may be active in the same cycle and are combined before
// clamping to [0, 2^STAT_W-1].
//   clk, reset : clock, async active-high reset (stat -> RESET_LEVEL)
//   inc_en     : decay tick selected this stat
//   dec_en     : accepted care targets this stat
//   stat       : registered stat value
module pet_stat_cell
    import pet_pkg::*;
#(
    parameter int STAT_W      = PET_STAT_W,
    parameter int DECAY_STEP  = 1,
    parameter int CARE_STEP   = 4,
    parameter int RESET_LEVEL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_en,
    input  logic              dec_en,
    output logic [STAT_W-1:0] stat
);
    localparam int MAXV = 2**STAT_W - 1;
    localparam int W    = STAT_W + 2;
    // Steps beyond full scale saturate the same way as full scale, so
    // trimming them keeps the sum inside W signed bits.
    localparam int INC  = (DECAY_STEP > MAXV) ? MAXV : DECAY_STEP;
    localparam int DEC  = (CARE_STEP  > MAXV) ? MAXV : CARE_STEP;

    logic [W-1:0]      sum;
    logic [STAT_W-1:0] stat_d;

    always_comb begin
        sum = {2'b00, stat};
        if (inc_en) sum = sum + W'(INC);
        if (dec_en) sum = sum - W'(DEC);
        // sum lies in [-MAXV, 2*MAXV]: top bit flags underflow, next bit overflow.
        if (sum[W-1])           stat_d = '0;
        else if (sum[STAT_W])   stat_d = '1;
        else                    stat_d = sum[STAT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stat <= STAT_W'(RESET_LEVEL);
        else       stat <= stat_d;
    end
endmodule

// File: rtl/pet_stats_engine.sv
// Pet statistics engine: NUM_STATS saturating need counters that grow on a
// periodic decay tick (random channel) and shrink on accepted care requests.
//   clk, reset : clock, async active-high reset
//   random     : LFSR byte; random % NUM_STATS picks the decay target
//   pause      : freezes the tick timer (care still accepted)
//   care       : care_valid / care_id / care_ready handshake (slave)
//   stats      : packed stats, stat i at [i*STAT_W +: STAT_W]
//   alert      : bit i high while stat i is saturated
//   tick       : one-cycle decay pulse
//   critical   : sticky, set once enough stats saturate together
module pet_stats_engine
    import pet_pkg::*;
#(
    parameter int NUM_STATS   = PET_NUM_STATS,
    parameter int STAT_W      = PET_STAT_W,
    parameter int TICK_PERIOD = 1000,
    parameter int DECAY_STEP  = 1,
    parameter int CARE_STEP   = 4,
    parameter int COOLDOWN    = 8,
    parameter int CRIT_COUNT  = 3,
    parameter int RESET_LEVEL = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  random,
    input  logic                        pause,
    pet_stats_engine_if.slave           care,
    output logic [NUM_STATS*STAT_W-1:0] stats,
    output logic [NUM_STATS-1:0]        alert,
    output logic                        tick,
    output logic                        critical
);
    localparam int ID_W  = $clog2(NUM_STATS);
    localparam int CNT_W = $clog2(TICK_PERIOD);
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [CNT_W-1:0]                  tick_cnt;
    logic [CD_W-1:0]                   cd_cnt;
    logic [7:0]                        sel;
    logic                              care_acc;
    logic [NUM_STATS-1:0]              inc_en, dec_en;
    logic [NUM_STATS-1:0][STAT_W-1:0]  stat_q;

    assign tick            = !pause && (tick_cnt == CNT_W'(TICK_PERIOD - 1));
    assign sel             = random % 8'(NUM_STATS);
    assign care.care_ready = (cd_cnt == '0);
    assign care_acc        = care.care_valid && care.care_ready;
    assign stats           = stat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      tick_cnt <= '0;
        else if (tick)  tick_cnt <= '0;
        else if (!pause) tick_cnt <= tick_cnt + 1'b1;
    end

    // Out-of-range care_id matches no cell but still starts the cooldown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cd_cnt <= '0;
        else if (care_acc)      cd_cnt <= CD_W'(COOLDOWN);
        else if (cd_cnt != '0)  cd_cnt <= cd_cnt - 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < NUM_STATS; i++) begin : g_cell
            assign inc_en[i] = tick && (sel == 8'(i));
            assign dec_en[i] = care_acc && (care.care_id == ID_W'(i));
            assign alert[i]  = &stat_q[i];

            pet_stat_cell #(
                .STAT_W      (STAT_W),
                .DECAY_STEP  (DECAY_STEP),
                .CARE_STEP   (CARE_STEP),
                .RESET_LEVEL (RESET_LEVEL)
            ) u_cell (
                .clk    (clk),
                .reset  (reset),
                .inc_en (inc_en[i]),
                .dec_en (dec_en[i]),
                .stat   (stat_q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            critical <= 1'b0;
        else if (popcount(16'(alert)) >= CRIT_COUNT)
            critical <= 1'b1;
    end
endmodule

// File: tb/tb_pet_stats_engine.sv
module tb_pet_stats_engine;
    localparam int NS   = 6;
    localparam int SW   = 4;
    localparam int TP   = 10;
    localparam int DEC  = 1;
    localparam int CARE = 4;
    localparam int CD   = 8;
    localparam int CRIT = 3;
    localparam int MAXV = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       random = 8'd0;
    logic             pause = 1'b0;
    logic [NS*SW-1:0] stats;
    logic [NS-1:0]    alert;
    logic             tick, critical;

    pet_stats_engine_if #(.NUM_STATS(NS)) cif ();

    pet_stats_engine #(
        .NUM_STATS(NS), .STAT_W(SW), .TICK_PERIOD(TP), .DECAY_STEP(DEC),
        .CARE_STEP(CARE), .COOLDOWN(CD), .CRIT_COUNT(CRIT), .RESET_LEVEL(0)
    ) dut (
        .clk(clk), .reset(reset), .random(random), .pause(pause), .care(cif),
        .stats(stats), .alert(alert), .tick(tick), .critical(critical)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS*SW-1:0] stats;
        logic [NS-1:0]    alert;
        logic             ready;
        logic             tick;
        logic             crit;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: plain integer bookkeeping of the engine's rules.
    int   ms[NS];
    int   m_phase;     // cycles since the last tick (or reset)
    int   m_cool;      // cycles of cooldown still owed
    bit   m_crit;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) ms[i] = 0;
        m_phase = 0; m_cool = 0; m_crit = 0;
    endtask

    // Apply one cycle of inputs, push the outputs expected during it, then
    // advance the model to the post-edge state.
    task automatic step(input logic [7:0] r, input bit p, input bit cv, input logic [2:0] cid);
        exp_t e;
        bit   tk, acc;
        int   nsat, d;
        random = r; pause = p; cif.care_valid = cv; cif.care_id = cid;
        tk  = !p && (m_phase == TP - 1);
        acc = cv && (m_cool == 0);
        nsat = 0;
        for (int i = 0; i < NS; i++) begin
            e.stats[i*SW +: SW] = SW'(ms[i]);
            e.alert[i] = (ms[i] == MAXV);
            if (ms[i] == MAXV) nsat++;
        end
        e.ready = (m_cool == 0); e.tick = tk; e.crit = m_crit;
        q.push_back(e);
        for (int i = 0; i < NS; i++) begin
            d = 0;
            if (tk && (int'(r) % NS) == i) d += DEC;
            if (acc && int'(cid) == i)     d -= CARE;
            ms[i] = ms[i] + d;
            if (ms[i] < 0)    ms[i] = 0;
            if (ms[i] > MAXV) ms[i] = MAXV;
        end
        if (nsat >= CRIT) m_crit = 1;
        if (tk) m_phase = 0; else if (!p) m_phase++;
        if (acc) m_cool = CD; else if (m_cool > 0) m_cool--;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (stats !== e.stats || alert !== e.alert || cif.care_ready !== e.ready ||
                tick !== e.tick || critical !== e.crit) begin
                n_err++;
                $display("FAIL cycle t=%0t: stats=%h alert=%b ready=%b tick=%b crit=%b, expected stats=%h alert=%b ready=%b tick=%b crit=%b",
                         $time, stats, alert, cif.care_ready, tick, critical,
                         e.stats, e.alert, e.ready, e.tick, e.crit);
            end
        end
    end

    task automatic check_reset_state(input string name);
        n_vec++;
        if (stats !== '0 || alert !== '0 || cif.care_ready !== 1'b1 ||
            tick !== 1'b0 || critical !== 1'b0) begin
            n_err++;
            $display("FAIL %s: stats=%h alert=%b ready=%b tick=%b crit=%b, expected all zero with ready=1",
                     name, stats, alert, cif.care_ready, tick, critical);
        end
    endtask

    initial begin
        bit accepted;
        cif.care_valid = 1'b0;
        cif.care_id    = '0;
        model_reset();
        #12;
        check_reset_state("power_on_reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Decay on stat2 only until it saturates.
        for (int c = 0; c < 200; c++) step(8'h02, 0, 0, 3'd0);

        // Mixed random traffic: care, pause, out-of-range ids.
        for (int c = 0; c < 600; c++)
            step(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)));

        // Pure decay: drive stats into saturation so critical trips.
        for (int c = 0; c < 1500; c++) step(8'($urandom), 0, 0, 3'd0);

        // Heavy care to pull stats back down; critical must hold.
        for (int c = 0; c < 400; c++)
            step(8'($urandom), ($urandom_range(0, 7) == 0), 1'b1, 3'($urandom_range(0, 7)));

        // Land an acceptance, go two cycles into cooldown, then reset async.
        accepted = 0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            accepted = (m_cool == 0);
            step(8'($urandom), 0, 1, 3'd1);
        end
        step(8'($urandom), 0, 0, 3'd0);
        step(8'($urandom), 0, 0, 3'd0);
        #2 reset = 1'b1;
        #1 check_reset_state("async_reset_mid_cooldown");
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // First tick after release must land TICK_PERIOD cycles later.
        for (int c = 0; c < 30; c++) step(8'd13, 0, 0, 3'd0);
        for (int c = 0; c < 40; c++) step(8'd13, (c % 7) < 2, 1, 3'd7);

        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pet_stats_engine.md
# pet_stats_engine

Parametrised pet-statistics engine for the tamagotchi core: holds NUM_STATS saturating need counters that grow on a periodic decay tick and shrink on accepted care actions. It sits between the button/action decoder, which issues care requests, and the display/behaviour logic, which reads the stat bus, alert vector and critical flag. It adds the following:
- configurable width, count and tick period
- valid/ready care handshake with a cooldown
- pause
- per-stat alerts
- a latched critical condition

## Interface
Parameters:
- NUM_STATS, 6, number of stat channels (2..16)
- STAT_W, 4, width of each stat; STAT_MAX = 2^STAT_W-1
- TICK_PERIOD, 1000, clk cycles between decay ticks (>=2)
- DECAY_STEP, 1, amount added to the selected stat per tick
- CARE_STEP, 4, amount subtracted from the target stat per accepted care
- COOLDOWN, 8, cycles care_ready stays low after an accepted care (0 = no cooldown)
- CRIT_COUNT, 3, number of simultaneously saturated stats that trips critical
- RESET_LEVEL, 0, reset value of every stat

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- random  in  8  free-running random byte from the LFSR
- pause  in  1  freezes tick counter and decay (care still accepted)
- care_valid  in  1  care request present
- care_id  in  $clog2(NUM_STATS)  target stat of the request
- care_ready  out  1  engine can accept care this cycle
- stats  out  NUM_STATS*STAT_W  packed stats; stat i at [i*STAT_W +: STAT_W]
- alert  out  NUM_STATS  bit i high while stat i == STAT_MAX
- tick  out  1  one-cycle pulse on each decay tick
- critical  out  1  sticky: set when popcount(alert) >= CRIT_COUNT; cleared only by reset

## Operation
- Reset values:
  - all stats = RESET_LEVEL
  - tick counter = 0
  - cooldown counter = 0
  - care_ready = 1
  - tick = 0
  - critical = 0
  - alert derived from stats
- Tick counter counts 0..TICK_PERIOD-1 while pause=0 and holds while pause=1. tick is asserted in the cycle the counter equals TICK_PERIOD-1 with pause=0, and the counter wraps to 0 in that cycle.
- On tick, the decay target is sel = random % NUM_STATS, with random sampled in the tick cycle. The selected stat gains DECAY_STEP, saturating at STAT_MAX.
- Care handshake:
  - Care is accepted when care_valid && care_ready.
  - The stat care_id loses CARE_STEP, saturating at 0.
  - care_id >= NUM_STATS is accepted and ignored, with no stat change but cooldown still started.
- Cooldown:
  - Acceptance loads the cooldown counter with COOLDOWN.
  - care_ready = (cooldown == 0). The counter decrements each cycle while nonzero.
  - With COOLDOWN=0, care_ready stays 1 and back-to-back acceptances are allowed.
- Simultaneous tick and care on the same stat: new = clamp(old + DECAY_STEP - CARE_STEP, 0, STAT_MAX). Compute in STAT_W+2 signed bits, then clamp, so no intermediate wrap.
- Simultaneous tick and care on different stats: both updates apply independently.
- Arithmetic: DECAY_STEP and CARE_STEP values larger than STAT_MAX clamp the result (e.g. 0 - 5 → 0, 14 + 5 → 15 at STAT_W=4). Stats never wrap.
- critical is evaluated on the registered alert vector and latched once set.
- Async reset mid-cooldown or mid-period returns everything to reset values immediately. The first tick after reset release occurs TICK_PERIOD cycles later.

## Timing
- Stat update latency: 1 cycle. The change is visible on stats the cycle after the tick or acceptance cycle.
- alert is combinational from registered stats, so it follows stats with no additional delay.
- critical asserts 1 cycle after alert reaches the threshold.
- care_ready drops the cycle after acceptance and rises again COOLDOWN cycles later. Total cycles from one acceptance to the next possible acceptance = COOLDOWN+1.
- tick period is exactly TICK_PERIOD cycles absent pause. Each paused cycle extends it by 1.

## Structure
- Shared package pet_pkg:
  - stat index constants STAT_HUNGER=0, STAT_HAPPINESS=1, STAT_HEALTH=2, STAT_HYGIENE=3, STAT_ENERGY=4, STAT_SOCIAL=5
  - default STAT_W
  - NUM_STATS default
  - helper function popcount
- One sub-module, pet_stat_cell, is instantiated NUM_STATS times. It holds a single STAT_W register with a combined saturating add/sub, taking inc_en, dec_en, DECAY_STEP and CARE_STEP. Selection, timer, cooldown and critical logic stay in the top module.

## Test plan
- Reset/decay: TICK_PERIOD=10, random held at 8'h02, no care → tick every 10 cycles; stat2 reads 1, 2, … and saturates at 15 after 15 ticks. alert[2]=1 and other stats stay 0.
- Care/cooldown: stat0=10, COOLDOWN=8, care_valid held with care_id=0 → accepted at t0 and t0+9. stat0 goes 10→6→2, care_ready is low for t0+1..t0+8, and a third acceptance leaves stat0 saturated at 0.
- Same-stat collision: stat1=2, tick and care on stat1 in the same cycle with DECAY_STEP=1, CARE_STEP=4 → stat1=0, not wrapped to 15.
- Modulo selection: NUM_STATS=6, random=8'd13 on tick → stat1 incremented. care_id=7 (>= NUM_STATS) → no stat change but care_ready drops.
- Pause/critical: assert pause for 5 cycles mid-period → tick delayed by exactly 5 cycles. Drive stats 0, 1 and 2 to 15 → critical rises 1 cycle after the third alert and stays 1 after care lowers them, until reset.
- Async reset asserted mid-cooldown with stats nonzero → all stats 0, care_ready=1 and critical=0 immediately, with no clk edge required.
